// File: rtl/rx_word_unpacker.sv
// Unpacks 128-bit words from a first-word-fall-through FIFO into OUT_WIDTH-bit
// beats on a valid/ready stream, least-significant beat first.
module rx_word_unpacker #(
  parameter int unsigned IN_WIDTH  = 128,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_rd_vld,
  input  logic [IN_WIDTH-1:0]  fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_first,
  output logic                 m_last,
  input  logic                 flush,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  localparam int unsigned BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IdxW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BEATS - 1);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   hold_q, hold_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q;
  logic                  pop;
  logic                  beat_accept;
  logic                  last_beat;
  int unsigned           beat_ofs;

  assign beat_accept = (state_q == StFull) & m_ready;
  assign last_beat   = (idx_q == LastIdx);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      StEmpty: begin
        pop = fifo_rd_vld & ~flush;
        if (pop) begin
          state_d = StFull;
          hold_d  = fifo_rd_data;
          idx_d   = '0;
        end
      end
      StFull: begin
        // Flush wins over both beat advance and reload.
        if (flush) begin
          state_d = StEmpty;
        end else if (beat_accept) begin
          if (last_beat) begin
            if (fifo_rd_vld) begin
              pop    = 1'b1;
              hold_d = fifo_rd_data;
              idx_d  = '0;
            end else begin
              state_d = StEmpty;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StEmpty;
    endcase
    if (rst) begin
      pop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      hold_q     <= '0;
      idx_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      word_cnt_q <= word_cnt_q + CNT_WIDTH'(pop);
    end
  end

  always_comb begin
    beat_ofs = 32'(idx_q) * OUT_WIDTH;
    m_data   = '0;
    if (state_q == StFull) begin
      m_data = hold_q[beat_ofs +: OUT_WIDTH];
    end
  end

  assign fifo_rd_en = pop;
  assign m_valid    = (state_q == StFull);
  assign busy       = (state_q == StFull);
  assign m_first    = (state_q == StFull) & (idx_q == '0);
  assign m_last     = (state_q == StFull) & last_beat;
  assign word_cnt   = word_cnt_q;

endmodule

// File: doc/rx_word_unpacker.md
Name: rx_word_unpacker

Overview:
- Downstream consumer of the RX prefetch FIFO (8-bit write side, 128-bit read side, first-word-fall-through).
- Pops one 128-bit word at a time and serialises it into OUT_WIDTH-bit beats on a valid/ready stream toward the Cortex-M1 bus-side RX data register.
- Provides a flush and simple status counters for firmware.

Parameters:
- IN_WIDTH, 128, FIFO read data width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 32, output beat width.
- BEATS, IN_WIDTH/OUT_WIDTH (=4), derived; beats per FIFO word; not overridable.
- CNT_WIDTH, 16, width of the word_cnt status counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_rd_vld  input  1  FIFO head word valid (prefetched; data already on fifo_rd_data).
- fifo_rd_data  input  IN_WIDTH  FIFO head word.
- fifo_rd_en  output  1  pop strobe to FIFO; combinational, single-cycle per word.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts beat when m_valid & m_ready.
- m_data  output  OUT_WIDTH  output beat.
- m_first  output  1  high with beat 0 of a word.
- m_last  output  1  high with beat BEATS-1 of a word.
- flush  input  1  discard remaining beats of the held word.
- busy  output  1  a word is held (state FULL).
- word_cnt  output  CNT_WIDTH  number of words popped since reset; wraps at 2^CNT_WIDTH.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=EMPTY, m_valid=0, m_data=0, m_first=0, m_last=0, busy=0, word_cnt=0, beat index=0, fifo_rd_en=0.
- fifo_rd_en is forced 0 while rst=1.
- Two states: EMPTY and FULL.
- EMPTY:
  - fifo_rd_en = fifo_rd_vld & ~flush.
  - On pop, fifo_rd_data is captured into the hold register, beat index=0, state goes to FULL.
- FULL:
  - m_valid=1.
  - m_data = hold[(idx+1)*OUT_WIDTH-1 : idx*OUT_WIDTH]; beat 0 is the LSBs (little-endian order).
  - m_first = (idx==0); m_last = (idx==BEATS-1).
- Beat accept (m_valid & m_ready) with idx<BEATS-1: idx increments.
- Beat accept with idx==BEATS-1:
  - If fifo_rd_vld and no flush: fifo_rd_en=1 in the same cycle, the new word is loaded, idx=0, state stays FULL. Zero bubble.
  - Otherwise state goes to EMPTY.
- Latency: fifo_rd_vld rising in EMPTY at cycle N gives the pop at N and m_valid/beat 0 at N+1.
- Throughput: with m_ready held at 1 and the FIFO never empty, one beat per cycle, with one pop every BEATS cycles.
- Backpressure: while m_valid & ~m_ready, m_data, m_first, m_last and idx are held stable. No pop occurs.
- flush:
  - In FULL: state goes to EMPTY next cycle and remaining beats are dropped.
  - A beat accepted in the flush cycle still counts as transferred.
  - No pop in any cycle where flush=1; flush has priority over load.
  - In EMPTY: no effect except suppressing the pop.
- word_cnt: increments by 1 on every cycle with fifo_rd_en=1; wraps from 2^CNT_WIDTH-1 to 0.
- fifo_rd_en is never asserted when fifo_rd_vld=0.
- Reset mid-word: the held word is discarded and the FIFO is not popped in the reset cycle.
- busy = (state==FULL).

Test Plan:
- Single word, m_ready=1: FIFO presents 0x0F0E0D0C_0B0A0908_07060504_03020100.
  - One pop cycle.
  - Beats 0x03020100 (first), 0x07060504, 0x0B0A0908, 0x0F0E0D0C (last) on 4 consecutive cycles.
  - Then m_valid=0 and word_cnt=1.
- Back-to-back: 3 words queued, m_ready=1.
  - 12 consecutive valid beats with no bubble.
  - fifo_rd_en pulses at cycles 0, 4, 8.
  - word_cnt=3.
- Backpressure: m_ready low for 5 cycles during beat 2.
  - m_data holds beat 2 value and m_last=0 throughout.
  - No fifo_rd_en.
  - Remaining beats follow once m_ready returns high.
- Flush: flush asserted while idx=1 with a second word waiting.
  - Beats 2–3 of the first word are dropped.
  - No pop in the flush cycle.
  - Next cycle EMPTY; the following cycle pops word 2; beat 0 of word 2 appears.
- Counter wrap and reset: force word_cnt to 0xFFFF, pop one word, and check word_cnt=0x0000.
  - Assert rst mid-word: next cycle m_valid=0, busy=0, word_cnt=0.
  - fifo_rd_en=0 during rst even with fifo_rd_vld=1.
